// File: rtl/rx_module.sv
`default_nettype none
// ============================================================================
// Module   : rx_module
// Brief    : UART receive engine: oversampled start qualification, LSB-first
//            data, optional even parity and 1/2 stop bits, done strobe + flags.
// Revision : 1.0 - initial release
// ============================================================================
module rx_module #(
   parameter int MAX_UART_DATA_W = 8,
   parameter int DATA_COUNTER_W  = 3,
   parameter int STOP_CONF_W     = 2,
   parameter int DATA_CONF_W     = 2,
   parameter int SAMPLE_COUNT_W  = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_i,
   input  logic                                 baud_en_i,
   input  logic                                 rx_en_i,
   input  logic [DATA_CONF_W+STOP_CONF_W:0]     rx_conf_i,
   input  logic                                 uart_rx_i,
   output logic [MAX_UART_DATA_W-1:0]           rx_data_o,
   output logic                                 rx_done_o,
   output logic                                 rx_busy_o,
   output logic                                 parity_err_o,
   output logic                                 frame_err_o
);

   localparam logic [SAMPLE_COUNT_W-1:0] c_MID  = SAMPLE_COUNT_W'((1 << (SAMPLE_COUNT_W-1)) - 1);
   localparam logic [SAMPLE_COUNT_W-1:0] c_WRAP = '1;
   localparam int                        c_MIN_DATA_BITS = 5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                      r_state;
   logic [1:0]                  r_sync;
   logic [SAMPLE_COUNT_W-1:0]   r_cnt;
   logic [DATA_COUNTER_W-1:0]   r_bit_cnt;
   logic [MAX_UART_DATA_W-1:0]  r_shift;
   logic                        r_par;
   logic                        r_par_err;
   logic                        r_frame_err;
   logic [DATA_CONF_W-1:0]      r_data_field;
   logic                        r_two_stop;
   logic                        r_par_en;

   logic                        w_line;
   logic                        w_wrap;
   logic                        w_last_data;
   logic                        w_last_stop;

   assign w_line      = r_sync[1];
   assign w_wrap      = baud_en_i && (r_cnt == c_WRAP);
   assign w_last_data = (r_bit_cnt == DATA_COUNTER_W'(c_MIN_DATA_BITS - 1) + DATA_COUNTER_W'(r_data_field));
   assign w_last_stop = !r_two_stop || (r_bit_cnt == DATA_COUNTER_W'(1));

   // Idle-high reset value keeps a freshly reset receiver from seeing a start.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], uart_rx_i};
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_par_err    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_data_field <= '0;
         r_two_stop   <= 1'b0;
         r_par_en     <= 1'b0;
         rx_data_o    <= '0;
         rx_done_o    <= 1'b0;
         rx_busy_o    <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         rx_done_o <= 1'b0;
         if (r_state != S_IDLE && !rx_en_i) begin
            // Abort: user-visible outputs keep the last completed frame.
            r_state   <= S_IDLE;
            rx_busy_o <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (baud_en_i && rx_en_i && !w_line) begin
                     r_state      <= S_START;
                     r_cnt        <= '0;
                     r_bit_cnt    <= '0;
                     r_shift      <= '0;
                     r_par        <= 1'b0;
                     r_par_err    <= 1'b0;
                     r_frame_err  <= 1'b0;
                     r_data_field <= rx_conf_i[DATA_CONF_W+STOP_CONF_W:STOP_CONF_W+1];
                     r_two_stop   <= |rx_conf_i[STOP_CONF_W:1];
                     r_par_en     <= rx_conf_i[0];
                     rx_busy_o    <= 1'b1;
                  end
               end
               S_START: begin
                  if (baud_en_i) begin
                     if (r_cnt == c_MID) begin
                        if (!w_line) begin
                           r_state <= S_DATA;
                           r_cnt   <= '0;
                        end else begin
                           r_state   <= S_IDLE;
                           rx_busy_o <= 1'b0;
                        end
                     end else begin
                        r_cnt <= r_cnt + SAMPLE_COUNT_W'(1);
                     end
                  end
               end
               S_DATA: begin
                  if (baud_en_i) begin
                     r_cnt <= r_cnt + SAMPLE_COUNT_W'(1);
                  end
                  if (w_wrap) begin
                     r_shift[r_bit_cnt] <= w_line;
                     r_par              <= r_par ^ w_line;
                     if (w_last_data) begin
                        r_bit_cnt <= '0;
                        r_state   <= r_par_en ? S_PARITY : S_STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + DATA_COUNTER_W'(1);
                     end
                  end
               end
               S_PARITY: begin
                  if (baud_en_i) begin
                     r_cnt <= r_cnt + SAMPLE_COUNT_W'(1);
                  end
                  if (w_wrap) begin
                     r_par_err <= w_line ^ r_par;
                     r_state   <= S_STOP;
                  end
               end
               S_STOP: begin
                  if (baud_en_i) begin
                     r_cnt <= r_cnt + SAMPLE_COUNT_W'(1);
                  end
                  if (w_wrap) begin
                     if (w_last_stop) begin
                        // Results land on entry so they are visible during DONE.
                        r_state      <= S_DONE;
                        rx_data_o    <= r_shift;
                        parity_err_o <= r_par_err;
                        frame_err_o  <= r_frame_err | !w_line;
                        rx_done_o    <= 1'b1;
                        rx_busy_o    <= 1'b0;
                     end else begin
                        r_frame_err <= r_frame_err | !w_line;
                        r_bit_cnt   <= r_bit_cnt + DATA_COUNTER_W'(1);
                     end
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state   <= S_IDLE;
                  rx_busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rx_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_module
// Brief    : Scoreboard bench for rx_module with directed serial frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_module;

   logic       clk = 1'b0;
   logic       rstn;
   logic       baud_en;
   logic       rx_en;
   logic [4:0] conf;
   logic       line;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_busy;
   logic       perr;
   logic       ferr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       fe;
      int         lat;
      int         start;
   } exp_t;

   exp_t q[$];

   rx_module dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .baud_en_i   (baud_en),
      .rx_en_i     (rx_en),
      .rx_conf_i   (conf),
      .uart_rx_i   (line),
      .rx_data_o   (rx_data),
      .rx_done_o   (rx_done),
      .rx_busy_o   (rx_busy),
      .parity_err_o(perr),
      .frame_err_o (ferr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every done strobe must match the oldest expected frame.
   always @(negedge clk) begin
      if (rstn && rx_done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got data %0h with no frame expected", rx_data);
         end else begin
            exp_t e;
            int   lat;
            e   = q.pop_front();
            lat = cyc - e.start;
            chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            chk("parity_err", {31'd0, perr}, {31'd0, e.pe});
            chk("frame_err", {31'd0, ferr}, {31'd0, e.fe});
            checks++;
            if (lat < e.lat - 2 || lat > e.lat + 2) begin
               errors++;
               $display("FAIL latency: got %0d expected %0d +/-2", lat, e.lat);
            end
         end
      end
   end

   task automatic send_bit(input logic b);
      line = b;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      line = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] d, input int nb, input bit pe, input logic pbit,
                        input int ns, input logic sbit, input bit epe, input bit efe);
      exp_t e;
      e.data  = d;
      e.pe    = epe;
      e.fe    = efe;
      e.lat   = 11 + 16 * (nb + int'(pe) + ns);
      e.start = cyc;
      q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(d[i]);
      if (pe) send_bit(pbit);
      for (int i = 0; i < ns; i++) send_bit(sbit);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      rstn    = 1'b0;
      baud_en = 1'b1;
      rx_en   = 1'b1;
      conf    = 5'b11000;
      line    = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("reset_data", {24'd0, rx_data}, 32'h0);
      chk("reset_done", {31'd0, rx_done}, 32'h0);
      chk("reset_busy", {31'd0, rx_busy}, 32'h0);
      chk("reset_perr", {31'd0, perr}, 32'h0);
      chk("reset_ferr", {31'd0, ferr}, 32'h0);
      rstn = 1'b1;
      idle(10);

      // 8N1 0xAA
      conf = 5'b11000;
      frame(8'hAA, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      idle(40);

      // 5E2 0x15: XOR of 10101 is 1
      conf = 5'b00011;
      frame(8'h15, 5, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0);
      idle(40);
      frame(8'h15, 5, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0);
      idle(40);

      // 8N1 0x3C with stop bit low
      conf = 5'b11000;
      frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
      idle(60);

      // Glitch: 4 cycles low, must be rejected as a false start
      line = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(30);
      chk("glitch_busy", {31'd0, rx_busy}, 32'h0);
      chk("glitch_data_held", {24'd0, rx_data}, 32'h3C);
      chk("glitch_ferr_held", {31'd0, ferr}, 32'h1);

      // Reset in the middle of a frame
      d = 8'h55;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      chk("busy_midframe", {31'd0, rx_busy}, 32'h1);
      rstn = 1'b0;
      #1;
      chk("rst_data", {24'd0, rx_data}, 32'h0);
      chk("rst_busy", {31'd0, rx_busy}, 32'h0);
      chk("rst_ferr", {31'd0, ferr}, 32'h0);
      chk("rst_perr", {31'd0, perr}, 32'h0);
      line = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      idle(40);

      // Abort during data bit 3
      d = 8'h0F;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      line = d[3];
      repeat (8) @(posedge clk);
      #1;
      rx_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_busy", {31'd0, rx_busy}, 32'h0);
      idle(20);
      chk("abort_data_held", {24'd0, rx_data}, 32'h0);
      rx_en = 1'b1;
      idle(20);
      frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      idle(40);

      // Back-to-back frames, no idle gap
      frame(8'h01, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      frame(8'hFE, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
      idle(20);

      for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("all_frames_done", q.size(), 32'd0);
      idle(20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rx_module.md
# rx_module

UART receive engine: the receive-side counterpart of `tx_module`, decoding frames on the serial input using the same configuration word and the same oversampling baud enable. It synchronises the asynchronous line, finds and qualifies the start bit, and samples data, parity and stop bits at bit centres. It presents each received word with a one-cycle done strobe and error flags. It sits between the pad and the UART register/FIFO layer, beside `tx_module`.

## Interface
- `MAX_UART_DATA_W`, 8: maximum data bits; width of `rx_data_o`.
- `DATA_COUNTER_W`, 3: width of the received-bit counter.
- `STOP_CONF_W`, 2: width of the stop-bit field in `rx_conf_i`.
- `DATA_CONF_W`, 2: width of the data-length field in `rx_conf_i`.
- `SAMPLE_COUNT_W`, 4: oversample counter width; 2^W ticks per bit, 16 by default.
- `clk_i`  in  1  single clock.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `baud_en_i`  in  1  oversample tick, shared with `tx_module`.
- `rx_en_i`  in  1  receiver enable.
- `rx_conf_i`  in  DATA_CONF_W+STOP_CONF_W+1  `{data[4:3], stop[2:1], parity_en[0]}`, same encoding as `tx_module`.
- `uart_rx_i`  in  1  asynchronous serial line, idle high.
- `rx_data_o`  out  MAX_UART_DATA_W  received word, right-justified, unused MSBs zero.
- `rx_done_o`  out  1  one-cycle strobe when a frame completes.
- `rx_busy_o`  out  1  high from start detection until the frame ends.
- `parity_err_o`  out  1  parity mismatch in the last frame.
- `frame_err_o`  out  1  a stop bit was sampled low in the last frame.

## Operation
- **Line synchroniser:** two flops, both reset to 1. All logic uses the synchronised value.
- **Data field:** data = 5 + field: 00→5, 01→6, 10→7, 11→8 bits.
- **Stop field:** 00→1 stop bit; 01 and 1x→2 stop bits.
- **Parity:** even parity, identical to `tx_module`. The parity bit equals the XOR of the data bits.
- **Config capture:** `rx_conf_i` is latched on start detection and is ignored mid-frame.
- **Bit order:** data is shifted in LSB first.
- **Sample counter:** advances only on `baud_en_i`, wraps 2^W−1→0.
- **State machine:**
  - IDLE: on a tick with `rx_en_i`=1 and line=0 → START, counter cleared.
  - START: on the tick where counter=2^(W−1)−1 (mid-bit): line=0 → DATA with counter cleared; line=1 → IDLE as a false start, with no outputs changed.
  - DATA: on the tick where counter=2^W−1, sample and shift one bit. After the last data bit → PARITY if enabled, else STOP.
  - PARITY: sample on the wrap tick, compare with the computed parity → STOP.
  - STOP: sample each configured stop bit on its wrap tick. Any stop sample of 0 sets the frame error. After the last stop bit → DONE.
  - DONE: lasts one clock. It updates `rx_data_o`, `parity_err_o` and `frame_err_o`, pulses `rx_done_o`, then → IDLE.
- A frame with errors still completes: data is presented and `rx_done_o` pulses.
- `rx_en_i`=0 in any non-IDLE state aborts to IDLE on the next clock. An aborted frame gives no `rx_done_o`, and all outputs hold.
- A new start is accepted from IDLE immediately after DONE. Line idle time is not required beyond the stop bit(s).

## Timing
- **Reset values:** `rx_data_o`=0, `rx_done_o`=0, `rx_busy_o`=0, `parity_err_o`=0, `frame_err_o`=0; state IDLE, counters 0.
- **Output registration:** all outputs are registered. `rx_data_o` and the error flags change only in the DONE cycle and hold until the next DONE.
- **`rx_busy_o`:** rises the clock after start detection and falls with the return to IDLE. It is low during the DONE cycle.
- **Latency:** with `baud_en_i` constantly high and 16x oversampling, `rx_done_o` rises 153–157 clocks after the line's falling start edge for 8N1. Each parity or stop bit adds 16 clocks.
- **Reset mid-frame:** `rstn_i` low returns everything to reset values asynchronously. No done pulse is produced.

## Test plan
- **8N1, 0xAA:** conf 5'b11000, `baud_en_i`=1, drive 0xAA from `tx_module` loopback → one `rx_done_o` pulse, `rx_data_o`=0xAA, both error flags 0, done 153–157 clocks after the start edge.
- **5E2, 0x15:** conf 5'b00011, parity bit 1 → `rx_data_o`=0x15, no errors. Repeat with the parity bit forced to 0 → `parity_err_o`=1, data still 0x15.
- **Framing error:** 8N1, 0x3C with the stop bit driven 0 → `frame_err_o`=1, `rx_data_o`=0x3C, `rx_done_o` pulses once.
- **Glitch rejection:** line low for 4 ticks, then high → no `rx_busy_o` beyond the START state, no `rx_done_o`, outputs unchanged.
- **Abort and reset:** `rx_en_i` dropped at data bit 3 → no done, returns to IDLE, and the next frame 0x55 is received correctly. `rstn_i` pulsed mid-frame → all outputs 0 immediately.
- **Back-to-back frames:** 0x01 then 0xFE with no idle gap → two done pulses with the correct data each.
